// File: rtl/async_ram_mp.sv
// Multi-port distributed RAM: combinational reads, byte-lane writes with lowest-port
// priority, collision reporting and a clear sweep that initialises every word.
`timescale 1ns/1ps
module async_ram_mp #(
  parameter int               DWIDTH   = 32,
  parameter int               AWIDTH   = 6,
  parameter int               DEPTH    = 1 << AWIDTH,
  parameter int               NWR      = 2,
  parameter int               NRD      = 2,
  parameter int               BYTEW    = 8,
  parameter int               BYPASS   = 0,
  parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NWR-1:0]            wr_en,
  input  logic [NWR*AWIDTH-1:0]     wr_addr,
  input  logic [NWR*DWIDTH-1:0]     wr_data,
  input  logic [NWR*(DWIDTH/BYTEW)-1:0] wr_be,
  input  logic [NRD*AWIDTH-1:0]     rd_addr,
  output logic [NRD*DWIDTH-1:0]     rd_data,
  input  logic                      clr,
  output logic                      ready,
  output logic                      collision,
  output logic [15:0]               collision_cnt
);

  localparam int                NB      = DWIDTH / BYTEW;
  localparam logic [AWIDTH:0]   DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST    = AWIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_reg, state_next;
  logic [AWIDTH-1:0] ptr_reg, ptr_next;
  logic              collision_reg;
  logic [15:0]       cnt_reg;
  logic              coll_now;
  logic [NWR-1:0]    wr_valid;
  logic [DWIDTH-1:0] mem [DEPTH];

  function automatic logic addr_ok(input logic [AWIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // State register, with the status registers that share its reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= CLEAR;
      ptr_reg       <= '0;
      collision_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      collision_reg <= coll_now;
      if (coll_now && cnt_reg != 16'hFFFF)
        cnt_reg <= cnt_reg + 16'd1;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      CLEAR: begin
        ptr_next = ptr_reg + AWIDTH'(1);
        if (ptr_reg == LAST) begin
          state_next = IDLE;
          ptr_next   = '0;
        end
      end
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    ready         = (state_reg == IDLE);
    collision     = collision_reg;
    collision_cnt = cnt_reg;
  end

  // A write takes part in commit, bypass and collision only when accepted and in range.
  generate
    for (genvar gi = 0; gi < NWR; gi++) begin : g_wr_valid
      assign wr_valid[gi] = wr_en[gi] && ready && addr_ok(wr_addr[gi*AWIDTH +: AWIDTH]);
    end
  endgenerate

  always_comb begin
    coll_now = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (wr_valid[p] && wr_valid[q] &&
            wr_addr[p*AWIDTH +: AWIDTH] == wr_addr[q*AWIDTH +: AWIDTH] &&
            |(wr_be[p*NB +: NB] & wr_be[q*NB +: NB]))
          coll_now = 1'b1;
      end
    end
  end

  // Ports are visited from highest to lowest so the lowest-index writer lands last and wins.
  always_ff @(posedge clk) begin
    if (state_reg == CLEAR) begin
      mem[ptr_reg] <= INIT_VAL;
    end else begin
      for (int p = NWR - 1; p >= 0; p--) begin
        if (wr_valid[p]) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[p*NB + b])
              mem[wr_addr[p*AWIDTH +: AWIDTH]][b*BYTEW +: BYTEW] <=
                wr_data[p*DWIDTH + b*BYTEW +: BYTEW];
          end
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AWIDTH-1:0] ra;
      logic [DWIDTH-1:0] word;

      assign ra = rd_addr[gi*AWIDTH +: AWIDTH];

      always_comb begin
        word = '0;
        if (ready && addr_ok(ra)) begin
          word = mem[ra];
          if (BYPASS != 0) begin
            for (int p = NWR - 1; p >= 0; p--) begin
              if (wr_valid[p] && wr_addr[p*AWIDTH +: AWIDTH] == ra) begin
                for (int b = 0; b < NB; b++) begin
                  if (wr_be[p*NB + b])
                    word[b*BYTEW +: BYTEW] = wr_data[p*DWIDTH + b*BYTEW +: BYTEW];
                end
              end
            end
          end
        end
      end

      assign rd_data[gi*DWIDTH +: DWIDTH] = word;
    end
  endgenerate

endmodule
